// File: rtl/exp5_sequenciador_pkg.sv
// Shared definitions for the measurement/transmission sequencer:
// state encoding, ASCII constants, frame geometry and character mapping.
package exp5_sequenciador_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_TX     = 4'd5,
        FIM_CICLO      = 4'd6,
        ESPERA         = 4'd7
    } estado_t;

    localparam logic [6:0] ASCII_NULO      = 7'h00;
    localparam logic [6:0] ASCII_ZERO      = 7'h30;
    localparam logic [6:0] ASCII_INTERROGA = 7'h3F;
    localparam logic [6:0] ASCII_CERQUILHA = 7'h23;

    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    // One BCD digit as ASCII; invalid digits and error frames show '?'.
    function automatic logic [6:0] digito_ascii(input logic [3:0] nibble, input logic erro);
        if (erro || (nibble > 4'd9)) begin
            return ASCII_INTERROGA;
        end
        return ASCII_ZERO + {3'b000, nibble};
    endfunction

    // Character at position idx of the frame: hundreds, tens, units, '#'.
    function automatic logic [6:0] char_quadro(input logic [11:0] medida,
                                               input logic        erro,
                                               input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    return digito_ascii(medida[11:8], erro);
            2'd1:    return digito_ascii(medida[7:4], erro);
            2'd2:    return digito_ascii(medida[3:0], erro);
            default: return ASCII_CERQUILHA;
        endcase
    endfunction

endpackage

// File: rtl/exp5_sequenciador_contador_m.sv
// Modulo-M counter with synchronous clear (zera), count enable (conta)
// and a terminal flag (fim) raised while the count equals M-1.
module contador_m #(
    parameter int M = 16,
    localparam int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [W-1:0] valor_q;

    // Count register: reset and zera clear, conta advances and wraps at M-1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valor_q <= '0;
        end else if (zera) begin
            valor_q <= '0;
        end else if (conta) begin
            valor_q <= fim ? '0 : valor_q + 1'b1;
        end
    end

    // Terminal count flag.
    always_comb begin
        fim = (valor_q == W'(M - 1));
    end

endmodule

// File: rtl/exp5_sequenciador.sv
// Frame sequencer: starts a measurement, waits for it (or times out),
// sends hundreds/tens/units/'#' to a serial transmitter, then idles for
// a fixed interval before the next frame unless parar is set.
module exp5_sequenciador #(
    parameter int INTERVALO      = 50_000_000,
    parameter int TIMEOUT_MEDIDA = 2_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        parar,
    input  logic [11:0] medida,
    input  logic        pronto_medida,
    input  logic        tx_pronto,
    output logic        medir,
    output logic        partida_serial,
    output logic [6:0]  dado_serial,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    import exp5_sequenciador_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    estado_t          estado_q, estado_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [11:0]      medida_q, medida_d;
    logic             erro_q, erro_d;

    logic zera_timeout, conta_timeout, fim_timeout;
    logic zera_intervalo, conta_intervalo, fim_intervalo;

    contador_m #(.M(TIMEOUT_MEDIDA)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timeout),
        .conta (conta_timeout),
        .fim   (fim_timeout)
    );

    contador_m #(.M(INTERVALO)) u_intervalo (
        .clock (clock),
        .reset (reset),
        .zera  (zera_intervalo),
        .conta (conta_intervalo),
        .fim   (fim_intervalo)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic; a measurement that arrives on the timeout cycle still counts.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:        if (!parar) estado_d = PREPARA;
            PREPARA:        estado_d = MEDE;
            MEDE:           estado_d = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: if (pronto_medida || fim_timeout) estado_d = TRANSMITE;
            TRANSMITE:      estado_d = AGUARDA_TX;
            AGUARDA_TX:     if (tx_pronto) estado_d = (idx_q == LAST_IDX) ? FIM_CICLO : TRANSMITE;
            FIM_CICLO:      estado_d = ESPERA;
            ESPERA:         if (fim_intervalo) estado_d = parar ? INICIAL : PREPARA;
            default:        estado_d = INICIAL;
        endcase
    end

    // Datapath registers: character index, latched measurement, error flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx_q    <= '0;
            medida_q <= '0;
            erro_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            medida_q <= medida_d;
            erro_q   <= erro_d;
        end
    end

    // Datapath next values; pronto_medida takes precedence over the timeout.
    always_comb begin
        idx_d    = idx_q;
        medida_d = medida_q;
        erro_d   = erro_q;
        case (estado_q)
            PREPARA: idx_d = '0;
            AGUARDA_MEDIDA: begin
                if (pronto_medida) begin
                    medida_d = medida;
                    erro_d   = 1'b0;
                end else if (fim_timeout) begin
                    erro_d   = 1'b1;
                end
            end
            AGUARDA_TX: if (tx_pronto && (idx_q != LAST_IDX)) idx_d = idx_q + 1'b1;
            default: ;
        endcase
    end

    // Moore outputs and counter controls decoded from the current state.
    always_comb begin
        medir           = (estado_q == MEDE);
        partida_serial  = (estado_q == TRANSMITE);
        pronto          = (estado_q == FIM_CICLO);
        zera_timeout    = (estado_q == PREPARA);
        conta_timeout   = (estado_q == AGUARDA_MEDIDA);
        zera_intervalo  = (estado_q == FIM_CICLO);
        conta_intervalo = (estado_q == ESPERA);
        dado_serial     = ASCII_NULO;
        if ((estado_q == TRANSMITE) || (estado_q == AGUARDA_TX)) begin
            dado_serial = char_quadro(medida_q, erro_q, idx_q);
        end
        erro      = erro_q;
        db_estado = estado_q;
    end

endmodule

// File: tb/tb_exp5_sequenciador.sv
// Bench for exp5_sequenciador with a short interval and timeout.
module tb_exp5_sequenciador;

    localparam int INTERVALO      = 20;
    localparam int TIMEOUT_MEDIDA = 30;

    logic        clock;
    logic        reset;
    logic        parar;
    logic [11:0] medida;
    logic        pronto_medida;
    logic        tx_pronto;
    logic        medir;
    logic        partida_serial;
    logic [6:0]  dado_serial;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    int n_vec = 0;
    int n_err = 0;
    int medir_cnt = 0;
    int partida_cnt = 0;
    int pronto_cnt = 0;
    int frames_done = 0;
    logic [6:0] exp_q[$];

    exp5_sequenciador #(
        .INTERVALO      (INTERVALO),
        .TIMEOUT_MEDIDA (TIMEOUT_MEDIDA)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .parar          (parar),
        .medida         (medida),
        .pronto_medida  (pronto_medida),
        .tx_pronto      (tx_pronto),
        .medir          (medir),
        .partida_serial (partida_serial),
        .dado_serial    (dado_serial),
        .pronto         (pronto),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        if (medir === 1'b1) medir_cnt <= medir_cnt + 1;
        if (partida_serial === 1'b1) partida_cnt <= partida_cnt + 1;
        if (pronto === 1'b1) pronto_cnt <= pronto_cnt + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Frame character from the rules: digit k is (m / 16^(2-k)) mod 16.
    function automatic logic [6:0] ref_char(input int m, input bit e, input int i);
        int d;
        if (i == 3) return 7'h23;
        d = (m / (16 ** (2 - i))) % 16;
        if (e || d > 9) return 7'h3F;
        return 7'(48 + d);
    endfunction

    task automatic wait_medir(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (medir === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_partida(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (partida_serial === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // One complete frame: measurement (or timeout), four characters, interval.
    task automatic run_frame(input logic [11:0] m, input int dly, input bit give,
                             input bit stray, input bit stop_mid);
        bit ok;
        bit e;
        int n;
        int w;
        logic [6:0] c;
        wait_medir(ok);
        chk("medir_seen", ok, 1);
        chk("mede_state", db_estado, 2);
        step();
        chk("medir_one_cycle", medir, 0);
        chk("aguarda_medida_state", db_estado, 3);
        if (give) begin
            repeat (dly - 1) step();
            medida = m;
            pronto_medida = 1'b1;
            step();
            pronto_medida = 1'b0;
            medida = 12'($urandom);
            e = 1'b0;
            chk("erro_after_medida", erro, 0);
            chk("transmite_after_medida", db_estado, 4);
        end else begin
            n = 0;
            while (db_estado === 4'd3 && n < 100) begin
                n++;
                step();
            end
            e = 1'b1;
            chk("timeout_cycles", n, TIMEOUT_MEDIDA);
            chk("erro_on_timeout", erro, 1);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(ref_char(int'(m), e, i));
        for (int i = 0; i < 4; i++) begin
            wait_partida(ok);
            chk("partida_seen", ok, 1);
            c = exp_q.pop_front();
            chk("char", dado_serial, c);
            if (stop_mid && i == 1) parar = 1'b1;
            if (stray && i == 0) tx_pronto = 1'b1;
            step();
            tx_pronto = 1'b0;
            chk("partida_one_cycle", partida_serial, 0);
            chk("aguarda_tx_state", db_estado, 5);
            w = $urandom_range(0, 4);
            repeat (w) begin
                step();
                chk("dado_stable", dado_serial, c);
            end
            tx_pronto = 1'b1;
            step();
            tx_pronto = 1'b0;
        end
        chk("pronto_pulse", pronto, 1);
        chk("fim_ciclo_state", db_estado, 6);
        chk("dado_idle", dado_serial, 0);
        step();
        chk("pronto_one_cycle", pronto, 0);
        n = 0;
        while (db_estado === 4'd7 && n < 100) begin
            n++;
            step();
        end
        chk("espera_cycles", n, INTERVALO);
        chk("after_espera_state", db_estado, parar ? 0 : 1);
        chk("erro_held", erro, e);
        frames_done++;
    endtask

    initial begin
        bit ok;
        int m0;
        reset = 1'b0;
        parar = 1'b1;
        medida = 12'h000;
        pronto_medida = 1'b0;
        tx_pronto = 1'b0;

        // Reset state.
        repeat (3) step();
        chk("rst_estado", db_estado, 0);
        chk("rst_medir", medir, 0);
        chk("rst_partida", partida_serial, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_dado", dado_serial, 0);
        chk("rst_erro", erro, 0);

        // parar held high: stay idle.
        reset = 1'b1;
        repeat (5) step();
        chk("idle_estado", db_estado, 0);
        chk("idle_no_medir", medir_cnt, 0);

        // Directed frames.
        parar = 1'b0;
        run_frame(12'h123, 5, 1'b1, 1'b0, 1'b0);
        run_frame(12'h000, 0, 1'b0, 1'b1, 1'b0);
        run_frame(12'h0A7, 3, 1'b1, 1'b0, 1'b0);
        run_frame(12'h456, TIMEOUT_MEDIDA, 1'b1, 1'b1, 1'b0);

        // Randomized frames.
        for (int k = 0; k < 6; k++) begin
            run_frame(12'($urandom_range(0, 4095)), $urandom_range(1, TIMEOUT_MEDIDA),
                      ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
        end

        // parar raised mid-frame: the frame completes, then idle.
        run_frame(12'h985, 7, 1'b1, 1'b0, 1'b1);
        m0 = medir_cnt;
        repeat (40) step();
        chk("stopped_estado", db_estado, 0);
        chk("stopped_no_medir", medir_cnt, m0);

        // Reset in AGUARDA_TX at index 2.
        parar = 1'b0;
        wait_medir(ok);
        chk("rstmid_medir_seen", ok, 1);
        step();
        medida = 12'h789;
        pronto_medida = 1'b1;
        step();
        pronto_medida = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_partida(ok);
            chk("rstmid_partida_seen", ok, 1);
            step();
            tx_pronto = 1'b1;
            step();
            tx_pronto = 1'b0;
        end
        wait_partida(ok);
        chk("rstmid_partida2_seen", ok, 1);
        chk("rstmid_char2", dado_serial, 7'h39);
        step();
        chk("rstmid_aguarda_tx", db_estado, 5);
        reset = 1'b0;
        step();
        chk("rstmid_estado", db_estado, 0);
        chk("rstmid_medir", medir, 0);
        chk("rstmid_partida", partida_serial, 0);
        chk("rstmid_pronto", pronto, 0);
        chk("rstmid_dado", dado_serial, 0);
        chk("rstmid_erro", erro, 0);
        reset = 1'b1;
        parar = 1'b1;
        tx_pronto = 1'b1;
        step();
        tx_pronto = 1'b0;
        repeat (5) step();
        chk("stray_tx_estado", db_estado, 0);
        chk("stray_tx_dado", dado_serial, 0);

        // Pulse totals across the whole run.
        chk("pronto_count", pronto_cnt, frames_done);
        chk("partida_count", partida_cnt, 4 * frames_done + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exp5_sequenciador.md
EXP5_SEQUENCIADOR -- requirements
Module: exp5_sequenciador

Interface
REQ-001 Parameter INTERVALO, default 50_000_000, clock cycles spent in ESPERA between frames (1 s at 50 MHz).
REQ-002 Parameter TIMEOUT_MEDIDA, default 2_500_000, max cycles in AGUARDA_MEDIDA before declaring a measurement error.
REQ-003 clock  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 parar  input  1  level; 1 = stop after the current frame, 0 = run continuously.
REQ-006 medida  input  12  three BCD digits from the measurement datapath: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-007 pronto_medida  input  1  one-cycle pulse; medida valid this cycle.
REQ-008 tx_pronto  input  1  one-cycle pulse; serial transmitter finished the current character.
REQ-009 medir  output  1  one-cycle pulse starting a measurement.
REQ-010 partida_serial  output  1  one-cycle pulse starting a character transmission.
REQ-011 dado_serial  output  7  ASCII character for the transmitter.
REQ-012 pronto  output  1  one-cycle pulse at frame end.
REQ-013 erro  output  1  level; 1 when the last frame came from a timeout.
REQ-014 db_estado  output  4  current state code.

Function
REQ-015 States and codes: INICIAL=0, PREPARA=1, MEDE=2, AGUARDA_MEDIDA=3, TRANSMITE=4, AGUARDA_TX=5, FIM_CICLO=6, ESPERA=7; codes 8-15 unused, return to INICIAL.
REQ-016 INICIAL: all pulses 0; parar=0 -> PREPARA; else stay.
REQ-017 PREPARA: char index to 0, timeout counter to 0 -> MEDE.
REQ-018 MEDE: medir=1 for exactly this cycle -> AGUARDA_MEDIDA.
REQ-019 AGUARDA_MEDIDA: pronto_medida=1 -> latch medida, erro=0, -> TRANSMITE.
REQ-020 AGUARDA_MEDIDA: counter reaches TIMEOUT_MEDIDA-1 without pronto_medida -> erro=1, -> TRANSMITE.
REQ-021 pronto_medida and timeout in the same cycle: pronto_medida wins.
REQ-022 Frame: 4 characters, index 0..3 = hundreds, tens, units, '#' (0x23).
REQ-023 Digit char = 0x30 + nibble; nibble > 9 -> '?' (0x3F); erro=1 -> digits 0..2 all '?'.
REQ-024 TRANSMITE: partida_serial=1 for one cycle; dado_serial = char[index] -> AGUARDA_TX.
REQ-025 dado_serial stable from TRANSMITE until tx_pronto is accepted; 0x00 outside TRANSMITE/AGUARDA_TX.
REQ-026 AGUARDA_TX: tx_pronto=1 and index<3 -> index+1, -> TRANSMITE; tx_pronto=1 and index=3 -> FIM_CICLO.
REQ-027 tx_pronto is sampled only in AGUARDA_TX; a pulse in any other state is ignored.
REQ-028 FIM_CICLO: pronto=1 for one cycle; interval counter to 0 -> ESPERA.
REQ-029 ESPERA: counter reaches INTERVALO-1 -> PREPARA if parar=0, INICIAL if parar=1.
REQ-030 parar is sampled only in INICIAL and at the end of ESPERA; a frame in progress always completes.
REQ-031 Latched medida and erro are held until the next latch or reset.

Reset
REQ-032 reset=0 at a clock edge: state INICIAL; index, counters and latched medida to 0; medir, partida_serial and pronto 0; dado_serial 0x00; erro 0; db_estado 0.
REQ-033 Reset has priority over every other input, including mid-frame; no partial character pulse is issued afterwards.

Structure
REQ-034 Shared package holds the state encoding, ASCII constants ('0'=0x30, '?'=0x3F, '#'=0x23) and frame length 4.
REQ-035 One sub-module, contador_m (parameterised mod-M counter with zera/conta/fim), instantiated twice: timeout and interval.

Verification (INTERVALO=20, TIMEOUT_MEDIDA=30)
REQ-036 parar=0, medida=0x123 pulsed 5 cycles after medir -> chars 0x31,0x32,0x33,0x23 in order, one partida_serial each, then one pronto pulse.
REQ-037 No pronto_medida -> erro=1 exactly 30 cycles after entering AGUARDA_MEDIDA; frame '?','?','?','#'.
REQ-038 medida=0x0A7 -> frame 0x30,0x3F,0x37,0x23; erro=0.
REQ-039 parar raised mid-frame -> frame completes, pronto pulses, 20 cycles in ESPERA, then INICIAL; no further medir.
REQ-040 reset=0 during AGUARDA_TX at index 2 -> next cycle state 0, all outputs 0; stray tx_pronto afterwards ignored.
REQ-041 pronto_medida and timeout in the same cycle -> medida latched, erro=0.
